// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// The DMEM_SUBWORD_EN macro enables byte-enable writes.
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_CMD   = 2'd1,
    ERR_ALIGN = 2'd2,
    ERR_RANGE = 2'd3
  } err_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the load/store path and dmem_responder.
// be_i exists only when DMEM_SUBWORD_EN is defined.
interface dmem_responder_if;
  import dmem_pkg::*;

  logic              req_i;
  logic              re_i;
  logic              we_i;
  logic [WORD_W-1:0] addr_i;
  logic [WORD_W-1:0] wdata_i;
`ifdef DMEM_SUBWORD_EN
  logic [BE_W-1:0]   be_i;
`endif
  logic              gnt_o;
  logic              rvalid_o;
  logic [WORD_W-1:0] rdata_o;
  logic              err_o;
  logic              busy_o;

`ifdef DMEM_SUBWORD_EN
  modport master (
    output req_i, re_i, we_i, addr_i, wdata_i, be_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, busy_o
  );
  modport slave (
    input  req_i, re_i, we_i, addr_i, wdata_i, be_i,
    output gnt_o, rvalid_o, rdata_o, err_o, busy_o
  );
`else
  modport master (
    output req_i, re_i, we_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, busy_o
  );
  modport slave (
    input  req_i, re_i, we_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o, busy_o
  );
`endif

endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// The read register is cleared on reset and loads zero when i_re is low.
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_re,
  input  logic              i_we,
  input  logic [BE_W-1:0]   i_be,
  input  logic [AW-1:0]     i_idx,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
  logic [WORD_W-1:0] r_rdata;

  // Byte-masked write; storage contents are never reset.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < BE_W; k++) begin
      if (i_we && i_be[k]) begin
        r_mem[i_idx][8*k +: 8] <= i_wdata[8*k +: 8];
      end
    end
  end

  // Read register: updates only on a response load, zero unless a read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_load) begin
      r_rdata <= i_re ? r_mem[i_idx] : '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: req/gnt handshake, fixed LATENCY, one-cycle response.
// Optional macro DMEM_SUBWORD_EN adds be_i byte-enable writes.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [AW-1:0]     r_idx;
  logic [WORD_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic              r_re;
  logic              r_we;
  err_t              r_err;

  logic              w_gnt;
  logic              w_enter_resp;
  logic [30:0]       w_diff;
  logic [BE_W-1:0]   w_be;
  err_t              w_err;
  logic [AW-1:0]     w_acc_idx;
  logic [WORD_W-1:0] w_acc_wdata;
  logic [BE_W-1:0]   w_acc_be;
  logic              w_acc_re;
  logic              w_acc_we;
  logic              w_acc_ok;
  logic [WORD_W-1:0] w_rdata;

  // Word offset from BASE_ADDR; a borrow lands in the upper bits and fails the range test.
  assign w_diff = {1'b0, bus.addr_i[31:2]} - {1'b0, BASE_ADDR[31:2]};

`ifdef DMEM_SUBWORD_EN
  assign w_be = bus.be_i;
`else
  assign w_be = '1;
`endif

  assign w_gnt        = bus.req_i && (r_state == IDLE) && rst_n;
  assign bus.gnt_o    = w_gnt;
  assign bus.busy_o   = (r_state != IDLE);
  assign bus.rvalid_o = (r_state == RESP);
  assign bus.err_o    = (r_state == RESP) && (r_err != ERR_NONE);
  assign bus.rdata_o  = w_rdata;

  // Grant-time error classification in priority order.
  always_comb begin
    w_err = ERR_NONE;
    if (bus.re_i == bus.we_i) begin
      w_err = ERR_CMD;
`ifdef DMEM_SUBWORD_EN
    end else if (bus.we_i && (bus.be_i == '0)) begin
      w_err = ERR_CMD;
`else
    end else if (bus.addr_i[1:0] != 2'b00) begin
      w_err = ERR_ALIGN;
`endif
    end else if (w_diff[30:AW] != '0) begin
      w_err = ERR_RANGE;
    end
  end

  // With LATENCY==1 the RAM access happens on the grant edge, so the live bus
  // is used in IDLE and the captured request otherwise.
  always_comb begin
    w_acc_idx   = r_idx;
    w_acc_wdata = r_wdata;
    w_acc_be    = r_be;
    w_acc_re    = r_re;
    w_acc_we    = r_we;
    w_acc_ok    = (r_err == ERR_NONE);
    if (r_state == IDLE) begin
      w_acc_idx   = w_diff[AW-1:0];
      w_acc_wdata = bus.wdata_i;
      w_acc_be    = w_be;
      w_acc_re    = bus.re_i;
      w_acc_we    = bus.we_i;
      w_acc_ok    = (w_err == ERR_NONE);
    end
  end

  assign w_enter_resp = rst_n &&
                        ((w_gnt && (LATENCY == 1)) ||
                         ((r_state == WAIT) && (r_cnt <= 4'd1)));

  // Handshake FSM, latency counter and request capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_re    <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= ERR_NONE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt) begin
            r_idx   <= w_diff[AW-1:0];
            r_wdata <= bus.wdata_i;
            r_be    <= w_be;
            r_re    <= bus.re_i;
            r_we    <= bus.we_i;
            r_err   <= w_err;
            r_cnt   <= LAT_M1;
            r_state <= (LATENCY > 1) ? WAIT : RESP;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            r_state <= RESP;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_enter_resp),
    .i_re    (w_acc_re && w_acc_ok),
    .i_we    (w_enter_resp && w_acc_we && w_acc_ok),
    .i_be    (w_acc_be),
    .i_idx   (w_acc_idx),
    .i_wdata (w_acc_wdata),
    .o_rdata (w_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (LATENCY=2, DEPTH_WORDS=1024).
// Exercises DMEM_SUBWORD_EN behaviour when that macro is defined.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference memory: word contents plus per-byte "has been written" flags.
  logic [31:0] model    [DEPTH];
  logic [3:0]  model_kn [DEPTH];

  typedef struct {
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt [13];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic set_idle();
    bus.req_i   = 1'b0;
    bus.re_i    = 1'b0;
    bus.we_i    = 1'b0;
    bus.addr_i  = '0;
    bus.wdata_i = '0;
`ifdef DMEM_SUBWORD_EN
    bus.be_i    = '0;
`endif
  endtask

  function automatic bit model_err(input logic re, input logic we,
                                   input logic [31:0] addr, input logic [3:0] be);
    longint unsigned a;
    a = longint'(addr);
    if (re == we) return 1'b1;
`ifdef DMEM_SUBWORD_EN
    if (we && (be == 4'h0)) return 1'b1;
`else
    if ((a % 4) != 0) return 1'b1;
    if (be == 4'hx) return 1'b1;
`endif
    if ((a < longint'(BASE)) || (a >= longint'(BASE) + DEPTH * 4)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int unsigned model_idx(input logic [31:0] addr);
    return int'((longint'(addr) - longint'(BASE)) / 4);
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    int unsigned idx;
    logic [3:0]  eff;
    idx = model_idx(addr);
`ifdef DMEM_SUBWORD_EN
    eff = be;
`else
    eff = 4'hF;
`endif
    for (int k = 0; k < 4; k++) begin
      if (eff[k]) begin
        model[idx][8*k +: 8] = wdata[8*k +: 8];
        model_kn[idx][k]     = 1'b1;
      end
    end
  endtask

  // Issue one request (caller is just past a negedge), return the response.
  task automatic txn(input logic re, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     output logic err, output logic [31:0] rd, output int unsigned lat);
    int unsigned n;
    bus.req_i   = 1'b1;
    bus.re_i    = re;
    bus.we_i    = we;
    bus.addr_i  = addr;
    bus.wdata_i = wdata;
`ifdef DMEM_SUBWORD_EN
    bus.be_i    = be;
`endif
    #1;
    n = 0;
    while (bus.gnt_o !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (bus.gnt_o !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL gnt_timeout: got no grant expected grant within 20 cycles");
      set_idle();
      err = 1'bx; rd = 'x; lat = 0;
      return;
    end
    @(negedge clk);
    // Garbage on the bus while waiting must not matter.
    bus.req_i   = 1'b0;
    bus.re_i    = 1'($urandom);
    bus.we_i    = 1'($urandom);
    bus.addr_i  = $urandom;
    bus.wdata_i = $urandom;
`ifdef DMEM_SUBWORD_EN
    bus.be_i    = 4'($urandom);
`endif
    #1;
    check("busy_in_wait", 32'(bus.busy_o), 32'd1);
    lat = 1;
    while (bus.rvalid_o !== 1'b1 && lat < 20) begin
      @(negedge clk); #1; lat++;
    end
    err = bus.err_o;
    rd  = bus.rdata_o;
    set_idle();
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got no end of test expected finish before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        err;
    logic [31:0] rd;
    int unsigned lat;
    int unsigned gap;
    bit          saw;

    for (int i = 0; i < DEPTH; i++) model_kn[i] = 4'h0;
    set_idle();

    // ---------------- reset ----------------
    bus.req_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("gnt_in_reset", 32'(bus.gnt_o), 32'd0);
    set_idle();
    rst_n = 1'b1;
    #1;
    check("rst_rvalid", 32'(bus.rvalid_o), 32'd0);
    check("rst_err",    32'(bus.err_o),    32'd0);
    check("rst_busy",   32'(bus.busy_o),   32'd0);
    check("rst_rdata",  bus.rdata_o,       32'd0);
    check("rst_gnt",    32'(bus.gnt_o),    32'd0);
    @(negedge clk);

    // ---------------- table-driven vectors ----------------
    vt[0]  = '{1'b0, 1'b1, 32'h1000_0000, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 32'h0};
    vt[1]  = '{1'b1, 1'b0, 32'h1000_0000, 32'h0,         4'hF, 1'b0, 1'b1, 32'hDEAD_BEEF};
`ifdef DMEM_SUBWORD_EN
    vt[2]  = '{1'b1, 1'b0, 32'h1000_0002, 32'h0,         4'hF, 1'b0, 1'b1, 32'hDEAD_BEEF};
`else
    vt[2]  = '{1'b1, 1'b0, 32'h1000_0002, 32'h0,         4'hF, 1'b1, 1'b1, 32'h0};
`endif
    vt[3]  = '{1'b0, 1'b1, 32'h1000_1000, 32'h5555_5555, 4'hF, 1'b1, 1'b1, 32'h0};
    vt[4]  = '{1'b1, 1'b0, 32'h1000_0000, 32'h0,         4'hF, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vt[5]  = '{1'b1, 1'b1, 32'h1000_0000, 32'h0,         4'hF, 1'b1, 1'b1, 32'h0};
    vt[6]  = '{1'b0, 1'b0, 32'h1000_0000, 32'h0,         4'hF, 1'b1, 1'b1, 32'h0};
    vt[7]  = '{1'b1, 1'b0, 32'h1000_0000, 32'h0,         4'hF, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vt[8]  = '{1'b1, 1'b0, 32'h0FFF_FFFC, 32'h0,         4'hF, 1'b1, 1'b1, 32'h0};
    vt[9]  = '{1'b0, 1'b1, 32'h1000_0FFC, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, 32'h0};
    vt[10] = '{1'b1, 1'b0, 32'h1000_0FFC, 32'h0,         4'hF, 1'b0, 1'b1, 32'hCAFE_F00D};
    vt[11] = '{1'b0, 1'b1, 32'h1000_0002, 32'h0,         4'h0, 1'b1, 1'b1, 32'h0};
    vt[12] = '{1'b1, 1'b0, 32'h1000_0000, 32'h0,         4'hF, 1'b0, 1'b1, 32'hDEAD_BEEF};

    for (int i = 0; i < 13; i++) begin
      txn(vt[i].re, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, err, rd, lat);
      check($sformatf("vec%0d_lat", i), lat, LAT);
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].exp_err));
      if (vt[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      if (vt[i].we && !vt[i].re && !vt[i].exp_err) model_write(vt[i].addr, vt[i].wdata, vt[i].be);
    end

    // ---------------- back-to-back with req held high ----------------
    @(negedge clk);
    bus.req_i = 1'b1; bus.re_i = 1'b0; bus.we_i = 1'b1;
    bus.addr_i = 32'h1000_0004; bus.wdata_i = 32'h1234_5678;
`ifdef DMEM_SUBWORD_EN
    bus.be_i = 4'hF;
`endif
    #1;
    check("b2b_first_gnt", 32'(bus.gnt_o), 32'd1);
    @(negedge clk);
    bus.re_i = 1'b1; bus.we_i = 1'b0;
    #1;
    gap = 1;
    saw = 1'b0;
    while (bus.gnt_o !== 1'b1 && gap < 20) begin
      if (bus.rvalid_o === 1'b1 && bus.err_o === 1'b0) saw = 1'b1;
      @(negedge clk); #1; gap++;
    end
    check("b2b_gnt_gap", gap, 32'd3);
    check("b2b_write_resp", 32'(saw), 32'd1);
    model_write(32'h1000_0004, 32'h1234_5678, 4'hF);
    @(negedge clk);
    set_idle();
    #1;
    lat = 1;
    while (bus.rvalid_o !== 1'b1 && lat < 20) begin
      @(negedge clk); #1; lat++;
    end
    check("b2b_read_lat", lat, LAT);
    check("b2b_read_rdata", bus.rdata_o, 32'h1234_5678);
    @(negedge clk);

    // ---------------- reset during an outstanding write ----------------
    txn(1'b0, 1'b1, 32'h1000_0010, 32'h1111_2222, 4'hF, err, rd, lat);
    model_write(32'h1000_0010, 32'h1111_2222, 4'hF);
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.re_i = 1'b0;
    bus.addr_i = 32'h1000_0010; bus.wdata_i = 32'hAAAA_AAAA;
`ifdef DMEM_SUBWORD_EN
    bus.be_i = 4'hF;
`endif
    #1;
    gap = 0;
    while (bus.gnt_o !== 1'b1 && gap < 20) begin
      @(negedge clk); #1; gap++;
    end
    check("rstmid_gnt", 32'(bus.gnt_o), 32'd1);
    @(negedge clk);
    set_idle();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("rstmid_busy", 32'(bus.busy_o), 32'd0);
    check("rstmid_rdata", bus.rdata_o, 32'd0);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (4) begin
      if (bus.rvalid_o === 1'b1) saw = 1'b1;
      @(negedge clk); #1;
    end
    check("rstmid_no_rvalid", 32'(saw), 32'd0);
    txn(1'b1, 1'b0, 32'h1000_0010, 32'h0, 4'hF, err, rd, lat);
    check("rstmid_old_data", rd, 32'h1111_2222);
    check("rstmid_read_err", 32'(err), 32'd0);

`ifdef DMEM_SUBWORD_EN
    // ---------------- byte-enable write ----------------
    txn(1'b0, 1'b1, 32'h1000_0000, 32'h0000_0000, 4'hF, err, rd, lat);
    model_write(32'h1000_0000, 32'h0, 4'hF);
    txn(1'b0, 1'b1, 32'h1000_0000, 32'hFFFF_FFFF, 4'b0010, err, rd, lat);
    model_write(32'h1000_0000, 32'hFFFF_FFFF, 4'b0010);
    check("be_write_err", 32'(err), 32'd0);
    txn(1'b1, 1'b0, 32'h1000_0000, 32'h0, 4'h0, err, rd, lat);
    check("be_read_rdata", rd, 32'h0000_FF00);
`endif

    // ---------------- randomized traffic vs reference model ----------------
    for (int i = 0; i < 160; i++) begin
      logic        re, we, eerr;
      logic [31:0] addr, wdata, mask;
      logic [3:0]  be;
      int unsigned kind, idx;
      kind = $urandom_range(0, 9);
      re   = 1'($urandom);
      we   = (kind == 0) ? re : !re;
      addr = BASE + 4 * $urandom_range(0, 31);
      if (kind == 1) addr = addr + $urandom_range(1, 3);
      if (kind == 2) addr = ($urandom_range(0, 1) == 1) ? BASE - 4 * $urandom_range(1, 64)
                                                       : BASE + DEPTH * 4 + 4 * $urandom_range(0, 64);
      wdata = $urandom;
      be    = 4'hF;
`ifdef DMEM_SUBWORD_EN
      be = 4'($urandom_range(1, 15));
      if (kind == 3) be = 4'h0;
`endif
      eerr = model_err(re, we, addr, be);
      txn(re, we, addr, wdata, be, err, rd, lat);
      check($sformatf("rnd%0d_lat", i), lat, LAT);
      check($sformatf("rnd%0d_err", i), 32'(err), 32'(eerr));
      if (eerr) begin
        check($sformatf("rnd%0d_err_rdata", i), rd, 32'd0);
      end else if (re) begin
        idx  = model_idx(addr);
        mask = {{8{model_kn[idx][3]}}, {8{model_kn[idx][2]}},
                {8{model_kn[idx][1]}}, {8{model_kn[idx][0]}}};
        check($sformatf("rnd%0d_rdata", i), rd & mask, model[idx] & mask);
      end else begin
        model_write(addr, wdata, be);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
